// File: rtl/roll_removal_sequencer_pkg.sv
// Shared definitions for the roll-removal sequencer and its sweep block.
// Grids are carried flat: bit r*WIDTH+c holds row r, column c.
package roll_grid_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SWEEP = 2'd1,
        OUT   = 2'd2
    } seq_state_t;

    // Enough bits to count every cell of the grid, including the all-removed case.
    function automatic int calcTw(input int width, input int depth);
        return $clog2(width * depth + 1);
    endfunction

    // Enough bits to hold the pass count up to and including the cap.
    function automatic int calcPw(input int maxPasses);
        return $clog2(maxPasses + 1);
    endfunction

    // Position of a cell inside the flat grid vector.
    function automatic int flatIndex(input int row, input int col, input int width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/roll_removal_sequencer_sweep.sv
// One full-grid removal sweep, purely combinational. Every decision is made
// against the incoming snapshot, so all removals of a sweep are simultaneous.
module roll_sweep
    import roll_grid_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int THRESH = 4
) (
    input  logic [WIDTH*DEPTH-1:0]           i_grid,
    output logic [WIDTH*DEPTH-1:0]           o_grid,
    output logic [calcTw(WIDTH, DEPTH)-1:0]  o_removed
);

    localparam int TW = calcTw(WIDTH, DEPTH);

    logic [DEPTH+1:0][WIDTH+1:0] w_pad;

    // Surround the grid with a ring of empty cells so edge cells need no bounds checks.
    always_comb begin
        w_pad = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                w_pad[r+1][c+1] = i_grid[flatIndex(r, c, WIDTH)];
            end
        end
    end

    // Count the eight neighbours of each roll and drop it when too few are occupied.
    always_comb begin
        int nbr;
        nbr       = 0;
        o_grid    = i_grid;
        o_removed = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                nbr = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0)) begin
                            nbr = nbr + int'(w_pad[r+1+dr][c+1+dc]);
                        end
                    end
                end
                if (i_grid[flatIndex(r, c, WIDTH)] && (nbr < THRESH)) begin
                    o_grid[flatIndex(r, c, WIDTH)] = 1'b0;
                    o_removed = o_removed + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/roll_removal_sequencer.sv
// Iterative roll-removal controller: load the grid row by row, sweep until a
// fixed point or the pass cap, then stream the final grid back out.
module roll_removal_sequencer
    import roll_grid_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int MAX_PASSES = 256,
    parameter int THRESH     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              row_valid,
    output logic                              row_ready,
    input  logic [WIDTH-1:0]                  row_data,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [WIDTH-1:0]                  res_row,
    output logic [calcTw(WIDTH, DEPTH)-1:0]   total_removed,
    output logic [calcPw(MAX_PASSES)-1:0]     passes,
    output logic                              capped,
    output logic                              done
);

    localparam int TW = calcTw(WIDTH, DEPTH);
    localparam int PW = calcPw(MAX_PASSES);
    localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    seq_state_t             r_state;
    seq_state_t             w_nextState;
    logic [WIDTH*DEPTH-1:0] r_grid;
    logic [RW-1:0]          r_rowCnt;
    logic [RW-1:0]          r_outCnt;
    logic [TW-1:0]          r_total;
    logic [PW-1:0]          r_passes;
    logic                   r_capped;
    logic                   r_done;

    logic [WIDTH*DEPTH-1:0] w_sweepGrid;
    logic [TW-1:0]          w_removed;
    logic                   w_rowAccept;
    logic                   w_resAccept;
    logic                   w_rowLast;
    logic                   w_outLast;
    logic [PW-1:0]          w_passesInc;
    logic                   w_hitCap;
    logic                   w_sweepIdle;

    roll_sweep #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) u_sweep (
        .i_grid    (r_grid),
        .o_grid    (w_sweepGrid),
        .o_removed (w_removed)
    );

    // Handshake and termination conditions shared by the FSM and the datapath.
    always_comb begin
        row_ready   = (r_state == LOAD) && !rst;
        res_valid   = (r_state == OUT);
        res_row     = r_grid[int'(r_outCnt)*WIDTH +: WIDTH];
        w_rowAccept = row_valid && row_ready;
        w_resAccept = res_valid && res_ready;
        w_rowLast   = (r_rowCnt == RW'(DEPTH - 1));
        w_outLast   = (r_outCnt == RW'(DEPTH - 1));
        w_passesInc = r_passes + PW'(1);
        w_hitCap    = (w_passesInc == PW'(MAX_PASSES));
        w_sweepIdle = (w_removed == '0);
    end

    // State register; reset always lands back in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a sweep that removes nothing, or that reaches the cap, ends the run.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LOAD:    if (w_rowAccept && w_rowLast) w_nextState = SWEEP;
            SWEEP:   if (w_sweepIdle || w_hitCap) w_nextState = OUT;
            OUT:     if (w_resAccept && w_outLast) w_nextState = LOAD;
            default: w_nextState = LOAD;
        endcase
    end

    // Grid, counters and result flags; the summary holds from the end of a sweep to the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grid   <= '0;
            r_rowCnt <= '0;
            r_outCnt <= '0;
            r_total  <= '0;
            r_passes <= '0;
            r_capped <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_rowAccept) begin
                        r_grid[int'(r_rowCnt)*WIDTH +: WIDTH] <= row_data;
                        if (w_rowLast) begin
                            r_rowCnt <= '0;
                            r_total  <= '0;
                            r_passes <= '0;
                            r_capped <= 1'b0;
                        end else begin
                            r_rowCnt <= r_rowCnt + RW'(1);
                        end
                    end
                end
                SWEEP: begin
                    r_grid   <= w_sweepGrid;
                    r_total  <= r_total + w_removed;
                    r_outCnt <= '0;
                    if (!w_sweepIdle) begin
                        r_passes <= w_passesInc;
                        if (w_hitCap) begin
                            r_capped <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (w_resAccept) begin
                        if (w_outLast) begin
                            r_outCnt <= '0;
                            r_done   <= 1'b1;
                        end else begin
                            r_outCnt <= r_outCnt + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign total_removed = r_total;
    assign passes        = r_passes;
    assign capped        = r_capped;
    assign done          = r_done;

endmodule

// File: tb/tb_roll_removal_sequencer.sv
// Scoreboard bench for roll_removal_sequencer. Two instances share every input:
// one with the default pass cap and one capped at two passes, so the capped
// behaviour is exercised alongside the normal one.
module tb_roll_removal_sequencer;

    typedef struct packed {
        logic [255:0] grid;
        logic [8:0]   total;
        logic [8:0]   passes;
        logic         capped;
        logic [15:0]  sweepLen;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rowValid;
    logic [15:0] rowData;
    logic        resReady;
    logic        rstSampled;

    logic        rowReady [2];
    logic        resValid [2];
    logic [15:0] resRow   [2];
    logic [8:0]  total    [2];
    logic        capped   [2];
    logic        done     [2];
    logic [8:0]  passesA;
    logic [1:0]  passesB;
    logic [8:0]  passesArr[2];

    int nChecks = 0;
    int nFails  = 0;
    int bpHold  = 0;

    resp_t expQA[$];
    resp_t expQB[$];

    assign passesArr[0] = passesA;
    assign passesArr[1] = {7'b0, passesB};

    always #5 clk = ~clk;

    // Remember whether reset was applied at the most recent edge.
    always @(posedge clk) rstSampled <= rst;

    roll_removal_sequencer #(
        .WIDTH(16), .DEPTH(16), .MAX_PASSES(256), .THRESH(4)
    ) dutA (
        .clk(clk), .rst(rst),
        .row_valid(rowValid), .row_ready(rowReady[0]), .row_data(rowData),
        .res_valid(resValid[0]), .res_ready(resReady), .res_row(resRow[0]),
        .total_removed(total[0]), .passes(passesA), .capped(capped[0]), .done(done[0])
    );

    roll_removal_sequencer #(
        .WIDTH(16), .DEPTH(16), .MAX_PASSES(2), .THRESH(4)
    ) dutB (
        .clk(clk), .rst(rst),
        .row_valid(rowValid), .row_ready(rowReady[1]), .row_data(rowData),
        .res_valid(resValid[1]), .res_ready(resReady), .res_row(resRow[1]),
        .total_removed(total[1]), .passes(passesB), .capped(capped[1]), .done(done[1])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input int dut, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, dut, act, exp, $time);
        end
    endtask

    function automatic resp_t mkResp(input logic [255:0] grid, input int tot, input int pas,
                                     input bit cap, input int sweeps);
        resp_t r;
        r.grid     = grid;
        r.total    = 9'(tot);
        r.passes   = 9'(pas);
        r.capped   = cap;
        r.sweepLen = 16'(sweeps);
        return r;
    endfunction

    // One monitor per instance: pops the expected run at the first result row,
    // checks every accepted row, backpressure stability, timing and the done pulse.
    for (genvar g = 0; g < 2; g++) begin : gMon
        int          loadCnt   = 0;
        int          sinceLoad = 0;
        int          outCnt    = 0;
        int          doneCnt   = 0;
        bit          armed     = 0;
        bit          inRun     = 0;
        bit          expectDone = 0;
        bit          stallPrev = 0;
        logic [15:0] stallRow  = '0;
        resp_t       cur       = '0;

        initial forever begin
            @(negedge clk);
            if (rstSampled) begin
                checkOutput("rst res_valid", g, int'(resValid[g]), 0);
                checkOutput("rst total", g, int'(total[g]), 0);
                checkOutput("rst passes", g, int'(passesArr[g]), 0);
                checkOutput("rst capped", g, int'(capped[g]), 0);
                checkOutput("rst done", g, int'(done[g]), 0);
                checkOutput("rst row_ready", g, int'(rowReady[g]), int'(!rst));
                loadCnt = 0; armed = 0; inRun = 0; outCnt = 0;
                expectDone = 0; stallPrev = 0;
            end else begin
                if (expectDone || done[g]) begin
                    checkOutput("done pulse", g, int'(done[g]), int'(expectDone));
                    if (expectDone) checkOutput("row_ready with done", g, int'(rowReady[g]), 1);
                end
                if (done[g]) doneCnt++;
                expectDone = 0;
                if (armed) sinceLoad++;
                if (resValid[g] && !inRun) begin
                    inRun = 1;
                    armed = 0;
                    outCnt = 0;
                    if (g == 0) begin
                        checkOutput("queue nonempty", g, expQA.size() > 0 ? 1 : 0, 1);
                        if (expQA.size() > 0) cur = expQA.pop_front();
                    end else begin
                        checkOutput("queue nonempty", g, expQB.size() > 0 ? 1 : 0, 1);
                        if (expQB.size() > 0) cur = expQB.pop_front();
                    end
                    checkOutput("total_removed", g, int'(total[g]), int'(cur.total));
                    checkOutput("passes", g, int'(passesArr[g]), int'(cur.passes));
                    checkOutput("capped", g, int'(capped[g]), int'(cur.capped));
                    checkOutput("sweep latency", g, sinceLoad, int'(cur.sweepLen) + 1);
                end
                if (resValid[g]) begin
                    if (stallPrev) checkOutput("stalled res_row", g, int'(resRow[g]), int'(stallRow));
                    if (resReady) begin
                        checkOutput($sformatf("res_row[%0d]", outCnt), g, int'(resRow[g]),
                                    int'(cur.grid[outCnt*16 +: 16]));
                        outCnt++;
                        stallPrev = 0;
                        if (outCnt == 16) begin
                            inRun = 0;
                            expectDone = 1;
                        end
                    end else begin
                        stallPrev = 1;
                        stallRow = resRow[g];
                    end
                end else if (stallPrev) begin
                    checkOutput("stalled res_valid", g, 0, 1);
                    stallPrev = 0;
                end
                if (rowValid && rowReady[g]) begin
                    loadCnt++;
                    if (loadCnt == 16) begin
                        loadCnt = 0;
                        armed = 1;
                        sinceLoad = 0;
                    end
                end
            end
        end
    end

    // Load one grid into both instances, queue the expected runs, then wait for
    // both to finish (or abort mid-sweep with reset when requested).
    task automatic applyStimulus(input logic [255:0] grid, input resp_t expA, input resp_t expB,
                                 input int stall, input bit abortSweep);
        int waitCycles;
        int targetA;
        int targetB;
        waitCycles = 0;
        while (!(rowReady[0] && rowReady[1]) && waitCycles < 200) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (waitCycles >= 200) checkOutput("row_ready timeout", 0, 0, 1);
        if (!abortSweep) begin
            expQA.push_back(expA);
            expQB.push_back(expB);
        end
        targetA = gMon[0].doneCnt + 1;
        targetB = gMon[1].doneCnt + 1;
        bpHold = stall;
        for (int r = 0; r < 16; r++) begin
            rowData  = grid[r*16 +: 16];
            rowValid = 1'b1;
            @(posedge clk); #1;
        end
        rowValid = 1'b0;
        rowData  = '0;
        if (abortSweep) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        waitCycles = 0;
        while (!(gMon[0].doneCnt >= targetA && gMon[1].doneCnt >= targetB) && waitCycles < 2000) begin
            if (bpHold > 0 && resValid[0]) begin
                resReady = 1'b0;
                bpHold--;
            end else begin
                resReady = 1'b1;
            end
            @(posedge clk); #1;
            waitCycles++;
        end
        resReady = 1'b1;
        if (waitCycles >= 2000) checkOutput("done timeout", 0, 0, 1);
    endtask

    initial begin
        logic [255:0] gZero, gOnes, gOnesRes, gSingle, gBlock, gBlockCap;
        gZero = '0;
        gOnes = '1;
        gOnesRes = '1;
        gOnesRes[0 +: 16]   = 16'h7FFE;
        gOnesRes[240 +: 16] = 16'h7FFE;
        gSingle = '0;
        gSingle[5*16 +: 16] = 16'h0020;
        gBlock = '0;
        gBlock[0 +: 16]  = 16'h0007;
        gBlock[16 +: 16] = 16'h0007;
        gBlock[32 +: 16] = 16'h0007;
        gBlockCap = '0;
        gBlockCap[16 +: 16] = 16'h0002;

        rst = 1'b1; rowValid = 1'b0; rowData = '0; resReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] empty grid");
        applyStimulus(gZero, mkResp(gZero, 0, 0, 0, 1), mkResp(gZero, 0, 0, 0, 1), 0, 0);
        $display("[TB] full grid");
        applyStimulus(gOnes, mkResp(gOnesRes, 4, 1, 0, 2), mkResp(gOnesRes, 4, 1, 0, 2), 0, 0);
        $display("[TB] single roll");
        applyStimulus(gSingle, mkResp(gZero, 1, 1, 0, 2), mkResp(gZero, 1, 1, 0, 2), 0, 0);
        $display("[TB] 3x3 block, uncapped and capped at two");
        applyStimulus(gBlock, mkResp(gZero, 9, 3, 0, 4), mkResp(gBlockCap, 8, 2, 1, 2), 0, 0);
        $display("[TB] single roll with result backpressure");
        applyStimulus(gSingle, mkResp(gZero, 1, 1, 0, 2), mkResp(gZero, 1, 1, 0, 2), 5, 0);
        $display("[TB] reset during sweep");
        applyStimulus(gBlock, mkResp(gZero, 0, 0, 0, 0), mkResp(gZero, 0, 0, 0, 0), 0, 1);
        $display("[TB] load after abort");
        applyStimulus(gOnes, mkResp(gOnesRes, 4, 1, 0, 2), mkResp(gOnesRes, 4, 1, 0, 2), 0, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue drained", 0, expQA.size(), 0);
        checkOutput("queue drained", 1, expQB.size(), 0);
        checkOutput("done count", 0, gMon[0].doneCnt, 6);
        checkOutput("done count", 1, gMon[1].doneCnt, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/roll_removal_sequencer.md
# roll_removal_sequencer

Sequential controller for the roll-removal datapath. It loads a WIDTH×DEPTH occupancy grid row by row, then applies one full-grid removal sweep per clock until a sweep removes nothing or a pass cap is reached. It accumulates the total number of rolls removed and the number of productive passes, then streams the final grid back out row by row. It is the top of the iterative-removal computation and owns the grid register and the one-pass sweep sub-block.

## Interface
- WIDTH, 16, grid columns (bits per row)
- DEPTH, 16, grid rows
- MAX_PASSES, 256, cap on productive sweeps (≥1)
- THRESH, 4, a roll is removable iff it has fewer than THRESH occupied neighbours
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- row_valid  in  1  load-stream valid
- row_ready  out  1  load-stream ready
- row_data  in  WIDTH  grid row; bit c = column c, 1 = roll present
- res_valid  out  1  result-stream valid
- res_ready  in  1  result-stream ready
- res_row  out  WIDTH  final grid row
- total_removed  out  TW=$clog2(WIDTH*DEPTH+1)  rolls removed over all passes
- passes  out  PW=$clog2(MAX_PASSES+1)  count of sweeps that removed ≥1 roll
- capped  out  1  run stopped at MAX_PASSES, not at a fixed point
- done  out  1  one-cycle pulse after the last result row is accepted

## Operation
- States: LOAD → SWEEP → OUT → LOAD.
- LOAD
  - row_ready=1.
  - Each row_valid&row_ready writes grid[row_cnt]; row_cnt increments.
  - Rows arrive row 0 first.
  - Acceptance of row DEPTH-1 moves to SWEEP and clears total_removed, passes, capped and row_cnt.
- SWEEP
  - row_ready=0; row_valid is ignored.
  - Each cycle the grid register takes the sweep output, and total_removed += removed.
  - All removals in a sweep are evaluated against the grid snapshot at the start of that sweep (simultaneous).
  - Neighbours are the 8 surrounding cells. Cells outside the grid count as empty.
  - If removed==0: go to OUT, with passes unchanged.
  - Otherwise passes++. If the new passes==MAX_PASSES, set capped=1 and go to OUT.
- OUT
  - res_valid=1; res_row=grid[out_cnt].
  - out_cnt increments on res_valid&res_ready.
  - res_row and res_valid stay stable while res_ready=0.
  - Acceptance of row DEPTH-1 pulses done on the next cycle and returns to LOAD.
- total_removed, passes and capped hold their values from the end of SWEEP until the next SWEEP entry.
- Widths
  - total_removed cannot overflow, because each roll is removed at most once.
  - The per-sweep removed count is TW bits wide and is zero-extended into the accumulator.

## Timing
- Reset values:
  - state=LOAD; grid all 0; row_cnt=out_cnt=0.
  - res_valid=0, total_removed=0, passes=0, capped=0, done=0.
  - row_ready=0 while rst=1, and 1 in the first cycle after rst drops.
- Load takes DEPTH accepted handshakes; back-to-back acceptance is one row per cycle.
- The first SWEEP cycle is the cycle after the last row is accepted.
- SWEEP lasts passes+1 cycles when uncapped, or MAX_PASSES cycles when capped.
- res_valid rises the cycle after the last SWEEP cycle.
- OUT takes ≥DEPTH cycles; it is exactly DEPTH when res_ready is held at 1.
- done pulses exactly one cycle after the final res handshake. row_ready is 1 in that same cycle.
- rst asserted in any state:
  - aborts the run on the next edge;
  - no done pulse;
  - the grid and counters are cleared.
- Degenerate grids:
  - An all-empty grid gives one SWEEP cycle, total 0, passes 0.
  - A grid that is already stable does the same, with nonzero contents retained.

## Structure
- Package roll_grid_pkg holds:
  - the state enum (LOAD, SWEEP, OUT);
  - the TW/PW width helper functions;
  - the flat-index convention: bit r*WIDTH+c = row r, column c.
- Sub-module roll_sweep is purely combinational, parameterised by WIDTH, DEPTH and THRESH.
  - Input: flat grid.
  - Outputs: next flat grid and removed count (TW bits).
- The parent owns all registers: grid, counters, state.

## Test plan
- All-zero 16×16 grid → one SWEEP cycle; total_removed=0, passes=0, capped=0; 16 result rows of 0; done pulses once.
- All-ones 16×16 grid → only the 4 corners are removed; total=4, passes=1, SWEEP lasts 2 cycles; row 0 and row 15 read back 0x7FFE.
- Single roll at (5,5) → total=1, passes=1; all result rows are 0.
- Full 3×3 block at rows 0–2, columns 0–2, rest empty:
  - 4 corners, then 4 edges, then the centre are removed;
  - total=9, passes=3, SWEEP lasts 4 cycles, capped=0.
- Same block with MAX_PASSES=2 → capped=1, passes=2, total=8; result row 1 = 0x0002, all other rows 0.
- Backpressure and reset:
  - Hold res_ready=0 for 5 cycles in OUT → res_row/res_valid stay stable.
  - Assert rst during SWEEP → next cycle state=LOAD with all outputs at reset values and no done pulse.
  - A following load runs normally.
